// File: rtl/mem_access_unit.sv
// Load/store front end for the byte-lane data memory: one request in flight,
// with range/size fault checking, write strobes and sign/zero-extended loads.
module mem_access_unit #(
    parameter int ADDR_BITS = 12,
    parameter int RD_LAT    = 1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [31:0] mem_raddress,
    output logic [31:0] mem_waddress,
    output logic [31:0] mem_datain,
    output logic [3:0]  mem_wr,
    input  logic [31:0] mem_dataout
);

    // state | meaning
    // IDLE  | waiting for a request, req_ready high
    // WRITE | single cycle with the byte strobe on mem_wr
    // READ  | waiting out the memory read latency
    // RESP  | response held until rsp_ready
    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    localparam int CNT_W = $clog2(RD_LAT + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;
    logic [3:0]         r_strb;
    logic [1:0]         r_size;
    logic               r_unsigned;
    logic               r_fault;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic [32:0]        w_nbytes;
    logic [32:0]        w_end;
    logic [3:0]         w_strb;
    logic               w_size_bad;
    logic               w_range_bad;
    logic               w_fault;
    logic [31:0]        w_wmask;
    logic [31:0]        w_ext;

    assign w_accept = req_valid && (r_state == IDLE);

    always_comb begin
        w_nbytes   = 33'd1;
        w_strb     = 4'b0000;
        w_size_bad = 1'b0;
        case (req_size)
            2'b00:   begin w_nbytes = 33'd1; w_strb = 4'b0001; end
            2'b01:   begin w_nbytes = 33'd2; w_strb = 4'b0011; end
            2'b10:   begin w_nbytes = 33'd4; w_strb = 4'b1111; end
            default: w_size_bad = 1'b1;
        endcase
    end

    // Last byte touched, computed in 33 bits so a wrap past 2^32 still faults
    assign w_end       = {1'b0, req_addr} + w_nbytes - 33'd1;
    assign w_range_bad = (w_end >= (33'd1 << ADDR_BITS));
    assign w_fault     = w_size_bad || w_range_bad;
    assign w_wmask     = {{8{w_strb[3]}}, {8{w_strb[2]}}, {8{w_strb[1]}}, {8{w_strb[0]}}};

    always_comb begin
        w_ext = mem_dataout;
        case (r_size)
            2'b00:   w_ext = {{24{~r_unsigned & mem_dataout[7]}},  mem_dataout[7:0]};
            2'b01:   w_ext = {{16{~r_unsigned & mem_dataout[15]}}, mem_dataout[15:0]};
            default: w_ext = mem_dataout;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        mem_wr      = 4'b0000;
        case (r_state)
            IDLE: begin
                req_ready = Reset_n;
                if (req_valid) begin
                    if (w_fault)     w_state_nxt = RESP;
                    else if (req_we) w_state_nxt = WRITE;
                    else             w_state_nxt = READ;
                end
            end
            WRITE: begin
                mem_wr      = r_strb;
                w_state_nxt = RESP;
            end
            READ: begin
                if (r_cnt == '0) w_state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_strb     <= '0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
            r_fault    <= 1'b0;
            r_cnt      <= '0;
        end else if (w_accept) begin
            r_addr     <= req_addr;
            r_wdata    <= req_wdata & w_wmask;
            r_rdata    <= '0;
            r_strb     <= w_strb;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_fault    <= w_fault;
            r_cnt      <= CNT_W'(RD_LAT);
        end else if (r_state == READ) begin
            if (r_cnt == '0) r_rdata <= w_ext;
            else             r_cnt   <= r_cnt - CNT_W'(1);
        end
    end

    assign rsp_rdata    = r_rdata;
    assign rsp_fault    = r_fault;
    assign mem_raddress = r_addr;
    assign mem_waddress = r_addr;
    assign mem_datain   = r_wdata;

endmodule
